// File: rtl/memarbiter_if.sv
// Requester (fetch/data) and memory-port signal bundle for memarbiter.
// slave = arbiter side, master = requesters plus memory device.
interface memarbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            ifreq;
    logic [AW-1:0]   ifaddr;
    logic            ifflush;
    logic [DW-1:0]   ifrdata;
    logic            ifvalid;
    logic            dreq;
    logic            dwe;
    logic [AW-1:0]   daddr;
    logic [DW-1:0]   dwdata;
    logic [DW/8-1:0] dwmask;
    logic [DW-1:0]   drdata;
    logic            dvalid;
    logic            mreq;
    logic            mwe;
    logic [AW-1:0]   maddr;
    logic [DW-1:0]   mwdata;
    logic [DW/8-1:0] mwmask;
    logic            mready;
    logic [DW-1:0]   mrdata;
    logic            stallfetch;
    logic            stallmem;

    modport slave (
        input  ifreq, ifaddr, ifflush, dreq, dwe, daddr, dwdata, dwmask, mready, mrdata,
        output ifrdata, ifvalid, drdata, dvalid, mreq, mwe, maddr, mwdata, mwmask,
               stallfetch, stallmem
    );

    modport master (
        output ifreq, ifaddr, ifflush, dreq, dwe, daddr, dwdata, dwmask, mready, mrdata,
        input  ifrdata, ifvalid, drdata, dvalid, mreq, mwe, maddr, mwdata, mwmask,
               stallfetch, stallmem
    );
endinterface

// File: rtl/memarbiter.sv
// Single-port memory arbiter between instruction fetch and the memory stage.
// Optional MEMARB_FAIRNESS_EN: alternate grants when both requesters are pending.
module memarbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    memarbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, IBUSY = 2'd1, DBUSY = 2'd2} state_t;

    state_t state, state_nxt;
    logic   drop, drop_nxt;
    logic   decide, fetch_ok, fetch_first, grant_d, grant_i;
    logic   ifvalid_c, dvalid_c;

    assign fetch_ok = bus.ifreq & ~bus.ifflush;
    // A grant can be issued whenever the port is free or becomes free this cycle.
    assign decide   = (state == IDLE) | bus.mready;

`ifdef MEMARB_FAIRNESS_EN
    logic lastdata;

    assign fetch_first = lastdata & fetch_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            lastdata <= 1'b0;
        else if (grant_d)
            lastdata <= 1'b1;
        else if (grant_i)
            lastdata <= 1'b0;
    end
`else
    assign fetch_first = 1'b0;
`endif

    assign grant_d = decide & bus.dreq & ~fetch_first;
    assign grant_i = decide & fetch_ok & ~grant_d;

    always_comb begin
        state_nxt = state;
        drop_nxt  = drop;
        if (decide) begin
            if (grant_d)
                state_nxt = DBUSY;
            else if (grant_i)
                state_nxt = IBUSY;
            else
                state_nxt = IDLE;
        end
        // A redirect during an outstanding fetch turns its completion into a silent one.
        if (state == IBUSY) begin
            if (bus.mready)
                drop_nxt = 1'b0;
            else if (bus.ifflush)
                drop_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            drop       <= 1'b0;
            bus.mreq   <= 1'b0;
            bus.mwe    <= 1'b0;
            bus.maddr  <= {AW{1'b0}};
            bus.mwdata <= {DW{1'b0}};
            bus.mwmask <= {(DW/8){1'b0}};
        end else begin
            state <= state_nxt;
            drop  <= drop_nxt;
            if (grant_d) begin
                bus.mreq   <= 1'b1;
                bus.mwe    <= bus.dwe;
                bus.maddr  <= bus.daddr;
                bus.mwdata <= bus.dwdata;
                bus.mwmask <= bus.dwmask;
            end else if (grant_i) begin
                bus.mreq   <= 1'b1;
                bus.mwe    <= 1'b0;
                bus.maddr  <= bus.ifaddr;
                bus.mwdata <= {DW{1'b0}};
                bus.mwmask <= {(DW/8){1'b0}};
            end else if (decide) begin
                bus.mreq   <= 1'b0;
            end
        end
    end

    assign ifvalid_c      = (state == IBUSY) & bus.mready & ~drop & ~bus.ifflush;
    assign dvalid_c       = (state == DBUSY) & bus.mready;
    assign bus.ifvalid    = ifvalid_c;
    assign bus.dvalid     = dvalid_c;
    assign bus.ifrdata    = bus.mrdata;
    assign bus.drdata     = bus.mrdata;
    assign bus.stallfetch = bus.ifreq & ~ifvalid_c & ~bus.ifflush;
    assign bus.stallmem   = bus.dreq & ~dvalid_c;
endmodule
